// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared types and constants for the SRAM arbiter
package sram_arbiter_pkg;

  // Width of the consecutive-data-grant counter
  localparam int ARB_STREAK_W = 4;

  // State register holds the owner of the transaction issued last cycle
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RESP_I = 2'd1,
    S_RESP_D = 2'd2
  } arb_state_t;

  // Winner of the current cycle's grant
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - inst/data request ports and SRAM port bundle
interface sram_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [31:0]       inst_rdata;

  logic              data_req;
  logic [3:0]        data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  logic              sram_en;
  logic [3:0]        sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  // Arbiter side
  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wen, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

  // Core and SRAM side
  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wen, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );

endinterface

// File: rtl/sram_arbiter_prio_grant.sv
// rtl/sram_arbiter_prio_grant.sv - data-priority grant with fetch streak limit
import sram_arbiter_pkg::*;

module arb_prio_grant #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inst_req,
  input  logic data_req,
  output logic gnt_i,
  output logic gnt_d
);

  localparam logic [ARB_STREAK_W-1:0] STREAK_MAX = ARB_STREAK_W'(MAX_DATA_STREAK);

  logic [ARB_STREAK_W-1:0] streak;

  // Data wins unless fetch has been passed over MAX_DATA_STREAK times in a row
  always_comb begin
    gnt_d = data_req & ~(inst_req & (streak == STREAK_MAX));
    gnt_i = inst_req & ~gnt_d;
  end

  // Count data grants that starve a waiting fetch; saturate at the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (gnt_i || !inst_req) begin
      streak <= '0;
    end else if (gnt_d && (streak != STREAK_MAX)) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - single-port SRAM arbiter for fetch and memory stages (option: SRAM_ARB_STATS_EN)
import sram_arbiter_pkg::*;

module sram_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cancel,
  sram_arbiter_if.slave     bus
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_inst_gnt,
  output logic [31:0]       stat_data_gnt,
  output logic [31:0]       stat_inst_stall
`endif
);

  arb_state_t        state;
  logic              kill;
  logic              rst_q;
  logic              blocked;
  logic              inst_req_m;
  logic              data_req_m;
  logic              gnt_i;
  logic              gnt_d;
  arb_owner_t        owner;
  logic [ADDR_W-1:0] issue_addr;

  // No grants in the reset cycle nor the cycle right after it
  always_comb begin
    blocked    = reset | rst_q;
    inst_req_m = bus.inst_req & ~blocked;
    data_req_m = bus.data_req & ~blocked;
  end

  arb_prio_grant #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_grant (
    .clk     (clk),
    .reset   (reset),
    .inst_req(inst_req_m),
    .data_req(data_req_m),
    .gnt_i   (gnt_i),
    .gnt_d   (gnt_d)
  );

  // Drive the SRAM from the winner in the grant cycle; idle port is all zero
  always_comb begin
    owner          = gnt_d ? OWN_D : OWN_I;
    issue_addr     = '0;
    bus.sram_en    = gnt_i | gnt_d;
    bus.sram_wen   = 4'h0;
    bus.sram_wdata = 32'h0;
    if (gnt_i || gnt_d) begin
      if (owner == OWN_D) begin
        issue_addr     = bus.data_addr;
        bus.sram_wen   = bus.data_wen;
        bus.sram_wdata = bus.data_wdata;
      end else begin
        issue_addr     = bus.inst_addr;
      end
    end
    bus.sram_addr    = issue_addr;
    bus.inst_addr_ok = gnt_i;
    bus.data_addr_ok = gnt_d;
  end

  // Responses land one cycle after issue; fetch responses can be killed by a flush
  always_comb begin
    bus.data_data_ok = (state == S_RESP_D) & ~reset;
    bus.inst_data_ok = (state == S_RESP_I) & ~kill & ~cancel & ~reset;
    bus.data_rdata   = bus.sram_rdata;
    bus.inst_rdata   = bus.sram_rdata;
  end

  // Track the owner of the in-flight transaction and a pending fetch kill
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      kill  <= 1'b0;
      rst_q <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      kill  <= cancel & gnt_i;
      if (gnt_d) begin
        state <= S_RESP_D;
      end else if (gnt_i) begin
        state <= S_RESP_I;
      end else begin
        state <= S_IDLE;
      end
    end
  end

`ifdef SRAM_ARB_STATS_EN
  // Free-running grant and fetch-stall counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_inst_gnt   <= 32'h0;
      stat_data_gnt   <= 32'h0;
      stat_inst_stall <= 32'h0;
    end else begin
      if (gnt_i) stat_inst_gnt <= stat_inst_gnt + 32'h1;
      if (gnt_d) stat_data_gnt <= stat_data_gnt + 32'h1;
      if (inst_req_m && !gnt_i) stat_inst_stall <= stat_inst_stall + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

  logic clk;
  logic reset;
  logic cancel;
  int   n_assert;
  int   n_fail;

  logic [31:0] mem [0:1023];

  sram_arbiter_if #(.ADDR_W(32)) bus ();

`ifdef SRAM_ARB_STATS_EN
  logic [31:0] stat_inst_gnt;
  logic [31:0] stat_data_gnt;
  logic [31:0] stat_inst_stall;
`endif

  sram_arbiter #(
    .MAX_DATA_STREAK(4),
    .ADDR_W(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cancel(cancel),
    .bus   (bus)
`ifdef SRAM_ARB_STATS_EN
    ,
    .stat_inst_gnt  (stat_inst_gnt),
    .stat_data_gnt  (stat_data_gnt),
    .stat_inst_stall(stat_inst_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM model, one-cycle read latency, byte-enabled writes
  always @(posedge clk) begin
    if (bus.sram_en) begin
      bus.sram_rdata <= mem[bus.sram_addr[11:2]];
      for (int b = 0; b < 4; b++) begin
        if (bus.sram_wen[b]) mem[bus.sram_addr[11:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic to_check();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  bit exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'h24010001;
    mem[1] = 32'h24020002;
    reset          = 1'b1;
    cancel         = 1'b0;
    bus.inst_req   = 1'b1;
    bus.inst_addr  = 32'hBFC00000;
    bus.data_req   = 1'b1;
    bus.data_wen   = 4'h0;
    bus.data_addr  = 32'h100;
    bus.data_wdata = 32'h0;
    bus.sram_rdata = 32'h0;

    // Reset cycle: requests present, nothing granted
    to_check();
    chk("rst_inst_addr_ok", {31'h0, bus.inst_addr_ok}, 32'h0);
    chk("rst_data_addr_ok", {31'h0, bus.data_addr_ok}, 32'h0);
    chk("rst_sram_en", {31'h0, bus.sram_en}, 32'h0);
    chk("rst_inst_data_ok", {31'h0, bus.inst_data_ok}, 32'h0);
    chk("rst_data_data_ok", {31'h0, bus.data_data_ok}, 32'h0);
    next_cycle();

    // Cycle after reset: still no grant
    reset        = 1'b0;
    bus.data_req = 1'b0;
    to_check();
    chk("post_rst_inst_addr_ok", {31'h0, bus.inst_addr_ok}, 32'h0);
    chk("post_rst_sram_en", {31'h0, bus.sram_en}, 32'h0);
    next_cycle();

    // Inst read, sustained for two cycles
    to_check();
    chk("i1_addr_ok", {31'h0, bus.inst_addr_ok}, 32'h1);
    chk("i1_sram_en", {31'h0, bus.sram_en}, 32'h1);
    chk("i1_sram_addr", bus.sram_addr, 32'hBFC00000);
    chk("i1_sram_wen", {28'h0, bus.sram_wen}, 32'h0);
    chk("i1_data_ok", {31'h0, bus.inst_data_ok}, 32'h0);
    next_cycle();
    bus.inst_addr = 32'hBFC00004;
    to_check();
    chk("i2_data_ok", {31'h0, bus.inst_data_ok}, 32'h1);
    chk("i2_rdata", bus.inst_rdata, 32'h24010001);
    chk("i2_addr_ok", {31'h0, bus.inst_addr_ok}, 32'h1);
    next_cycle();
    bus.inst_req = 1'b0;
    to_check();
    chk("i3_data_ok", {31'h0, bus.inst_data_ok}, 32'h1);
    chk("i3_rdata", bus.inst_rdata, 32'h24020002);
    chk("i3_sram_en", {31'h0, bus.sram_en}, 32'h0);
    next_cycle();

    // Data write then read-back
    bus.data_req   = 1'b1;
    bus.data_wen   = 4'hF;
    bus.data_addr  = 32'h100;
    bus.data_wdata = 32'hDEADBEEF;
    to_check();
    chk("w_addr_ok", {31'h0, bus.data_addr_ok}, 32'h1);
    chk("w_sram_wen", {28'h0, bus.sram_wen}, 32'hF);
    chk("w_sram_addr", bus.sram_addr, 32'h100);
    chk("w_sram_wdata", bus.sram_wdata, 32'hDEADBEEF);
    next_cycle();
    bus.data_wen = 4'h0;
    to_check();
    chk("w_data_ok", {31'h0, bus.data_data_ok}, 32'h1);
    chk("r_addr_ok", {31'h0, bus.data_addr_ok}, 32'h1);
    chk("r_sram_wen", {28'h0, bus.sram_wen}, 32'h0);
    next_cycle();
    bus.data_req = 1'b0;
    to_check();
    chk("r_data_ok", {31'h0, bus.data_data_ok}, 32'h1);
    chk("r_rdata", bus.data_rdata, 32'hDEADBEEF);
    next_cycle();

    // Fresh reset so statistics cover only the contention run
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Contention: both requests held for 10 cycles
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'hBFC00000;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h100;
    for (int i = 0; i < 10; i++) begin
      to_check();
      chk($sformatf("cont_data_addr_ok_%0d", i), {31'h0, bus.data_addr_ok}, {31'h0, exp_d[i]});
      chk($sformatf("cont_inst_addr_ok_%0d", i), {31'h0, bus.inst_addr_ok}, {31'h0, !exp_d[i]});
      if (i > 0) begin
        chk($sformatf("cont_data_data_ok_%0d", i), {31'h0, bus.data_data_ok}, {31'h0, exp_d[i-1]});
        chk($sformatf("cont_inst_data_ok_%0d", i), {31'h0, bus.inst_data_ok}, {31'h0, !exp_d[i-1]});
      end
      next_cycle();
    end
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    to_check();
    chk("cont_last_inst_data_ok", {31'h0, bus.inst_data_ok}, 32'h1);
    chk("cont_last_inst_rdata", bus.inst_rdata, 32'h24010001);
`ifdef SRAM_ARB_STATS_EN
    chk("stat_data_gnt", stat_data_gnt, 32'd8);
    chk("stat_inst_gnt", stat_inst_gnt, 32'd2);
    chk("stat_inst_stall", stat_inst_stall, 32'd8);
`endif
    next_cycle();

    // Cancel in the grant cycle kills the next response
    bus.inst_req = 1'b1;
    cancel       = 1'b1;
    to_check();
    chk("k1_addr_ok", {31'h0, bus.inst_addr_ok}, 32'h1);
    next_cycle();
    cancel = 1'b0;
    to_check();
    chk("k2_killed_data_ok", {31'h0, bus.inst_data_ok}, 32'h0);
    chk("k2_addr_ok", {31'h0, bus.inst_addr_ok}, 32'h1);
    next_cycle();
    // Cancel during the response cycle suppresses it; data still granted
    bus.inst_req = 1'b0;
    bus.data_req = 1'b1;
    cancel       = 1'b1;
    to_check();
    chk("k3_cancel_data_ok", {31'h0, bus.inst_data_ok}, 32'h0);
    chk("k3_data_addr_ok", {31'h0, bus.data_addr_ok}, 32'h1);
    next_cycle();
    bus.data_req = 1'b0;
    to_check();
    chk("k4_data_data_ok", {31'h0, bus.data_data_ok}, 32'h1);
    chk("k4_data_rdata", bus.data_rdata, 32'hDEADBEEF);
    next_cycle();
    cancel       = 1'b0;
    bus.inst_req = 1'b1;
    to_check();
    chk("k5_addr_ok", {31'h0, bus.inst_addr_ok}, 32'h1);
    next_cycle();
    bus.inst_req = 1'b0;
    to_check();
    chk("k6_data_ok", {31'h0, bus.inst_data_ok}, 32'h1);
    chk("k6_rdata", bus.inst_rdata, 32'h24010001);
    next_cycle();

    // Reset hits the cycle after a data read grant
    bus.data_req = 1'b1;
    to_check();
    chk("m1_addr_ok", {31'h0, bus.data_addr_ok}, 32'h1);
    next_cycle();
    reset        = 1'b1;
    bus.data_req = 1'b0;
    to_check();
    chk("m2_data_ok_in_reset", {31'h0, bus.data_data_ok}, 32'h0);
    next_cycle();
    reset        = 1'b0;
    bus.data_req = 1'b1;
    to_check();
    chk("m3_data_ok_after_reset", {31'h0, bus.data_data_ok}, 32'h0);
    chk("m3_addr_ok_after_reset", {31'h0, bus.data_addr_ok}, 32'h0);
    next_cycle();
    to_check();
    chk("m4_addr_ok", {31'h0, bus.data_addr_ok}, 32'h1);
    next_cycle();
    bus.data_req = 1'b0;
    to_check();
    chk("m5_data_ok", {31'h0, bus.data_data_ok}, 32'h1);
    chk("m5_rdata", bus.data_rdata, 32'hDEADBEEF);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
